// File: rtl/spram_be_pkg.sv
// spram_be_pkg: write-mode codes, clear-FSM states and the byte-merge helper shared by spram_be.
package spram_be_pkg;
    localparam int WM_READ_FIRST = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE = 2;
    localparam int MAX_W = 1024;
    localparam int MAX_B = MAX_W / 8;

    typedef enum logic {CLEAR, RUN} clr_state_t;

    // Word-size agnostic: callers zero-extend into MAX_W and truncate the result.
    function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_B-1:0] be);
        logic [MAX_W-1:0] m;
        for (int i = 0; i < MAX_B; i++)
            m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/spram_be_clear_ctrl.sv
// spram_be_clear_ctrl: post-reset sweep FSM; walks ptr over the array and holds ready low until done.
module spram_be_clear_ctrl
    import spram_be_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] ptr
);
    clr_state_t state, state_d;
    logic [ADDR_WIDTH-1:0] ptr_d;

    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= CLEAR;
            ptr <= '0;
        end else begin
            state <= state_d;
            ptr <= ptr_d;
        end

    always_comb begin
        state_d = state;
        ptr_d = ptr;
        if (state == CLEAR) begin
            ptr_d = ptr + 1'b1;
            if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = RUN;
                ptr_d = '0;
            end
        end
    end

    assign ready = state == RUN;
    assign clr_we = state == CLEAR;
endmodule

// File: rtl/spram_be.sv
// spram_be: single-port RAM with byte enables, collision read modes, optional output register and valid flag.
// Define SPRAM_BE_CLEAR_EN to sweep the array to CLEAR_VAL after every reset.
module spram_be
    import spram_be_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    parameter int WRITE_MODE = 0,
    parameter int OUT_REG = 0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [NB-1:0]         be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      din,
    output logic                  ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic acc, in_range, rd_v, wr_en, clr_we;
    logic [WIDTH-1:0] old_w, rd_d, wr_data;
    logic [NB-1:0] wr_be;
    logic [ADDR_WIDTH-1:0] wr_addr, clr_ptr;

    if (WIDTH % 8 != 0 || WIDTH > MAX_W) begin : g_width_chk
        $error("spram_be: WIDTH must be a multiple of 8 and at most %0d", MAX_W);
    end
    if (DEPTH < 2 || WRITE_MODE < WM_READ_FIRST || WRITE_MODE > WM_NO_CHANGE) begin : g_param_chk
        $error("spram_be: illegal DEPTH or WRITE_MODE");
    end

`ifdef SPRAM_BE_CLEAR_EN
    spram_be_clear_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_clr (
        .clk(clk), .rst_n(rst_n), .ready(ready), .clr_we(clr_we), .ptr(clr_ptr)
    );
`else
    assign ready = 1'b1;
    assign clr_we = 1'b0;
    assign clr_ptr = '0;
`endif

    assign acc = req && ready && rst_n;
    assign in_range = {1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign old_w = in_range ? mem[addr] : '0;
    assign rd_d = (we && in_range && WRITE_MODE == WM_WRITE_FIRST)
                ? WIDTH'(be_merge(MAX_W'(old_w), MAX_W'(din), MAX_B'(be))) : old_w;
    assign rd_v = acc && !(we && WRITE_MODE == WM_NO_CHANGE);

    // The clear engine owns the write port while it runs.
    assign wr_en = (clr_we && rst_n) || (acc && we && in_range);
    assign wr_addr = clr_we ? clr_ptr : addr;
    assign wr_data = clr_we ? CLEAR_VAL : din;
    assign wr_be = clr_we ? '1 : be;

    always_ff @(posedge clk)
        for (int i = 0; i < NB; i++)
            if (wr_en && wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];

    if (OUT_REG != 0) begin : g_oreg
        logic p_v;
        logic [WIDTH-1:0] p_d;
        always_ff @(posedge clk)
            if (!rst_n) begin
                p_v <= 1'b0;
                dout_valid <= 1'b0;
                dout <= '0;
            end else begin
                p_v <= rd_v;
                if (rd_v) p_d <= rd_d;
                dout_valid <= p_v;
                if (p_v) dout <= p_d;
            end
    end else begin : g_noreg
        always_ff @(posedge clk)
            if (!rst_n) begin
                dout_valid <= 1'b0;
                dout <= '0;
            end else begin
                dout_valid <= rd_v;
                if (rd_v) dout <= rd_d;
            end
    end
endmodule

// File: tb/tb_spram_be.sv
// tb_spram_be: directed checks of four spram_be configurations driven in lockstep.
// u0 RF/lat1/64, u1 WF/lat2/64, u2 NC/lat1/48, u3 RF/lat2/64; odd instances have the output register.
module tb_spram_be;
    localparam logic [31:0] CV = 32'h5A5A5A5A;
`ifdef SPRAM_BE_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, req, we;
    logic [3:0] be;
    logic [5:0] addr;
    logic [31:0] din;
    logic [3:0][31:0] dout;
    logic [3:0] dv, rdy;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    spram_be #(.DEPTH(64), .WIDTH(32), .WRITE_MODE(0), .OUT_REG(0), .CLEAR_VAL(CV)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .ready(rdy[0]), .dout(dout[0]), .dout_valid(dv[0]));
    spram_be #(.DEPTH(64), .WIDTH(32), .WRITE_MODE(1), .OUT_REG(1), .CLEAR_VAL(CV)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .ready(rdy[1]), .dout(dout[1]), .dout_valid(dv[1]));
    spram_be #(.DEPTH(48), .WIDTH(32), .WRITE_MODE(2), .OUT_REG(0), .CLEAR_VAL(CV)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .ready(rdy[2]), .dout(dout[2]), .dout_valid(dv[2]));
    spram_be #(.DEPTH(64), .WIDTH(32), .WRITE_MODE(0), .OUT_REG(1), .CLEAR_VAL(CV)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .din(din),
        .ready(rdy[3]), .dout(dout[3]), .dout_valid(dv[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit w, input logic [3:0] b, input int a, input logic [31:0] d);
        req = r;
        we = w;
        be = b;
        addr = 6'(a);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 0, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        cyc(1, 0, 4'h0, a, 32'h0);
        for (int k = 0; k < 4; k += 2) begin
            check($sformatf("%s u%0d valid", tag, k), 32'(dv[k]), 32'd1);
            check($sformatf("%s u%0d dout", tag, k), dout[k], e[k]);
        end
        idle();
        for (int k = 1; k < 4; k += 2) begin
            check($sformatf("%s u%0d valid", tag, k), 32'(dv[k]), 32'd1);
            check($sformatf("%s u%0d dout", tag, k), dout[k], e[k]);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (rdy != 4'hF && n < 200) begin
            idle();
            n++;
        end
        check("ready after clear", 32'(rdy), 32'hF);
    endtask

    // Call right after a reset edge: counts cycles with ready low, dropping a write issued mid-clear.
    task automatic clear_count(input string tag);
        int cnt [4] = '{default: 0};
        rst_n = 1'b1;
        for (int c = 0; c < 100; c++) begin
            for (int k = 0; k < 4; k++) if (!rdy[k]) cnt[k]++;
            if (rdy == 4'hF) break;
            check($sformatf("%s valid in clear", tag), 32'(dv), 32'h0);
            if (c == 10) cyc(1, 1, 4'hF, 7, 32'h0);
            else idle();
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("%s u%0d ready-low cycles", tag, k), 32'(cnt[k]), (k == 2) ? 32'd48 : 32'd64);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        idle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset u%0d valid", k), 32'(dv[k]), 32'd0);
            check($sformatf("reset u%0d dout", k), dout[k], 32'h0);
        end
        check("reset ready", 32'(rdy), CLR_EN ? 32'h0 : 32'hF);
`ifdef SPRAM_BE_CLEAR_EN
        clear_count("clr1");
        for (int a = 0; a < 64; a++)
            rd_chk($sformatf("clr a%0d", a), a, CV, CV, (a < 48) ? CV : 32'h0, CV);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        repeat (30) idle();
        rst_n = 1'b0;
        idle();
        clear_count("clr2");
`else
        rst_n = 1'b1;
`endif
        // Byte-enable merge and read latency
        cyc(1, 1, 4'hF, 5, 32'hAABBCCDD);
        cyc(1, 1, 4'h5, 5, 32'h11223344);
        idle();
        idle();
        cyc(1, 0, 4'h0, 5, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1 lat1 u%0d valid", k), 32'(dv[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) check($sformatf("t1 lat1 u%0d dout", k), dout[k], 32'hAA22CC44);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1 lat2 u%0d valid", k), 32'(dv[k]), (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("t1 lat2 u%0d dout", k), dout[k], 32'hAA22CC44);
        end
        // Collision modes
        cyc(1, 1, 4'hF, 3, 32'h0);
        idle();
        idle();
        cyc(1, 1, 4'hF, 3, 32'hDEADBEEF);
        check("t2 u0 RF valid", 32'(dv[0]), 32'd1);
        check("t2 u0 RF dout", dout[0], 32'h0);
        check("t2 u2 NC valid", 32'(dv[2]), 32'd0);
        check("t2 u2 NC dout", dout[2], 32'hAA22CC44);
        idle();
        check("t2 u1 WF valid", 32'(dv[1]), 32'd1);
        check("t2 u1 WF dout", dout[1], 32'hDEADBEEF);
        check("t2 u3 RF valid", 32'(dv[3]), 32'd1);
        check("t2 u3 RF dout", dout[3], 32'h0);
        check("t2 u0 after valid", 32'(dv[0]), 32'd0);
        check("t2 u2 after valid", 32'(dv[2]), 32'd0);
        // Streaming reads
        for (int a = 0; a < 16; a++) cyc(1, 1, 4'hF, a, 32'(3 * a));
        idle();
        idle();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) cyc(1, 0, 4'h0, i, 32'h0);
            else idle();
            for (int k = 0; k < 4; k++) begin
                bit ev;
                int j;
                j = (k % 2 == 0) ? i : i - 1;
                ev = j >= 0 && j < 16;
                check($sformatf("t3 i%0d u%0d valid", i, k), 32'(dv[k]), 32'(ev));
                if (ev) check($sformatf("t3 i%0d u%0d dout", i, k), dout[k], 32'(3 * j));
            end
        end
        // Reset with a read in flight; the access in the reset cycle must be dropped
        cyc(1, 0, 4'h0, 5, 32'h0);
        rst_n = 1'b0;
        cyc(1, 1, 4'hF, 9, 32'hFFFFFFFF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4 rst u%0d valid", k), 32'(dv[k]), 32'd0);
            check($sformatf("t4 rst u%0d dout", k), dout[k], 32'h0);
        end
        rst_n = 1'b1;
        idle();
        check("t4 no late valid", 32'(dv), 32'h0);
        wait_ready();
        rd_chk("t4 a5", 5, CLR_EN ? CV : 32'd15, CLR_EN ? CV : 32'd15, CLR_EN ? CV : 32'd15, CLR_EN ? CV : 32'd15);
        rd_chk("t4 a9", 9, CLR_EN ? CV : 32'd27, CLR_EN ? CV : 32'd27, CLR_EN ? CV : 32'd27, CLR_EN ? CV : 32'd27);
        // Out-of-range on the 48-deep instance
        cyc(1, 1, 4'hF, 50, 32'h12345678);
        cyc(1, 1, 4'hF, 47, 32'hCAFEF00D);
        idle();
        idle();
        rd_chk("t5 a50", 50, 32'h12345678, 32'h12345678, 32'h0, 32'h12345678);
        rd_chk("t5 a47", 47, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D);
        rd_chk("t5 a2", 2, CLR_EN ? CV : 32'd6, CLR_EN ? CV : 32'd6, CLR_EN ? CV : 32'd6, CLR_EN ? CV : 32'd6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spram_be.md
Name: spram_be

Overview:
- Parametrised single-port synchronous RAM that succeeds the basic SPRAM.
- Adds per-byte write enables, a selectable write-collision read mode, an optional output register stage and a read-data valid flag.
- Used as the generic on-chip buffer and scratchpad for datapath blocks that need partial-word updates.
- Optional clear-on-reset engine sweeps the whole array to a known value after reset.

Parameters:
- DEPTH, 256, number of words; any value ≥2, not required to be a power of two.
- WIDTH, 32, word width in bits; must be a multiple of 8 (elaboration-time error otherwise).
- WRITE_MODE, 0, read-data behaviour on a write access: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR_VAL, 0, WIDTH-bit word written by the clear engine (used only with the optional feature).
- Derived (local): ADDR_WIDTH = $clog2(DEPTH), NB = WIDTH/8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- req  in  1  access request, sampled on the rising clk edge.
- we  in  1  1 = write, 0 = read; qualified by req.
- be  in  NB  byte enables for writes; be[i] selects din[8i+7:8i]. Ignored on reads.
- addr  in  ADDR_WIDTH  word address.
- din  in  WIDTH  write data.
- ready  out  1  block accepts accesses this cycle.
- dout  out  WIDTH  read data.
- dout_valid  out  1  dout carries new data this cycle.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is synchronous and active-low.
- Accept rule: an access is accepted when req && ready at the clk edge. Requests with ready=0 are dropped; there is no queueing.
- Write access: for every i with be[i]=1, mem[addr][8i+7:8i] <= din byte i. Bytes with be[i]=0 are unchanged. be=0 is a legal no-op write.
- Read access: returns mem[addr]. dout_valid=1 exactly LAT cycles after acceptance, where LAT = 1 + OUT_REG.
- Write access, read data by WRITE_MODE:
  - READ_FIRST: return the pre-write word, with dout_valid.
  - WRITE_FIRST: return the merged post-write word (old bytes where be=0, new where be=1), with dout_valid.
  - NO_CHANGE: dout holds its value and dout_valid stays 0.
- dout holds its last value whenever dout_valid=0. One access per cycle, fully pipelined; back-to-back accesses give back-to-back valids.
- Out-of-range address (addr ≥ DEPTH, possible only for non-power-of-two DEPTH): write is ignored; read returns all zeros with dout_valid asserted as normal.
- Reset (rst_n=0 at an edge):
  - dout=0, dout_valid=0, and all pipeline valid bits cleared.
  - Reads in flight are discarded; no dout_valid appears after reset.
  - An access presented in the reset cycle is not performed.
  - Memory contents are preserved (except as stated in Optional Feature).
- ready: constant 1 without the optional feature.

Optional Feature:
- Macro: SPRAM_BE_CLEAR_EN.
- Defined: a clear FSM with states CLEAR and RUN.
  - Reset forces CLEAR with ptr=0. In CLEAR, ready=0 and mem[ptr] <= CLEAR_VAL (all bytes), one word per cycle, ptr++.
  - After writing ptr=DEPTH-1, go to RUN; ready=1 from the next cycle. First accepted access is at the cycle DEPTH+1 edges after rst_n rises.
  - Reset asserted mid-clear restarts from ptr=0.
  - dout_valid stays 0 throughout CLEAR.
- Undefined: no FSM; ready=1; memory is uninitialised after reset.

Decomposition:
- Package spram_be_pkg holds:
  - write-mode constants WM_READ_FIRST=0, WM_WRITE_FIRST=1, WM_NO_CHANGE=2;
  - clear-FSM state typedef (CLEAR, RUN);
  - a byte-merge function (old word, new word, be) → merged word.
- Sub-module spram_be_clear_ctrl: clear FSM, address pointer and ready generation. Instantiated only under SPRAM_BE_CLEAR_EN. The top muxes its address and write data into the array port.

Test Plan (WIDTH=32, DEPTH=64 unless stated):
1. Byte-enable write: write 0xAABBCCDD, be=4'b1111 to addr 5; then write 0x11223344, be=4'b0101 to addr 5; read addr 5 → dout=0xAA22CC44, dout_valid exactly 1 cycle after the read (OUT_REG=0), 2 cycles after (OUT_REG=1).
2. Collision modes: addr 3 holds 0x00000000; write 0xDEADBEEF, be=4'b1111.
   - READ_FIRST → dout=0x00000000, valid.
   - WRITE_FIRST → dout=0xDEADBEEF, valid.
   - NO_CHANGE → dout unchanged, dout_valid=0.
3. Streaming: 16 back-to-back reads of addrs 0..15 preloaded with addr*3 → 16 consecutive valids with data 0,3,…,45 in order, no gaps, for both OUT_REG values.
4. Reset mid-flight: OUT_REG=1; issue read, assert rst_n=0 on the next edge → no dout_valid pulse afterward, dout=0; memory contents still readable after reset.
5. Non-power-of-two: DEPTH=48; write addr 50 → no effect on any word; read addr 50 → 0x00000000 with valid; addr 47 read/write normal.
6. SPRAM_BE_CLEAR_EN, CLEAR_VAL=0x5A5A5A5A:
   - After reset, ready=0 for exactly 64 cycles; a req during clear is dropped.
   - Then read every address → 0x5A5A5A5A.
   - Re-assert reset at cycle 30 → clear restarts from addr 0 and runs a full 64 cycles.
